frame_array_ctrl: RTL and testbench
===================================

# frame_array_ctrl

Sequencer for the motion tracker's frame store. Accepts luma samples from the capture front end as `iEnLatch`/`iYdata` strobes and ping-pongs whole frames between two banks of a single-port pixel memory. For every incoming pixel it reads the co-located pixel of the previous frame, then writes the new one. It presents {current, reference} pixel pairs to the downstream motion-compare datapath.

## Interface
- `COLS`, 640, pixels per line
- `ROWS`, 480, lines per frame
- `ADDR_W`, 19, pixel index width; must satisfy 2^ADDR_W ≥ COLS*ROWS
- `iClock`  in  1  system clock, all logic on rising edge
- `iReset`  in  1  synchronous, active-high reset
- `iStart`  in  1  level; sampled in IDLE; arms capture and clears sticky flags
- `iStop`  in  1  pulse; request to stop after the current frame completes
- `iFrameStart`  in  1  start-of-frame pulse (vsync)
- `iEnLatch`  in  1  pixel strobe, 1 cycle wide
- `iYdata`  in  8  luma, valid with `iEnLatch`
- `oMemAddr`  out  ADDR_W+1  {bank, pixel index}
- `oMemRe`  out  1  memory read strobe; data returned on `iMemRdata` one cycle later
- `oMemWe`  out  1  memory write strobe
- `oMemWdata`  out  8  write data
- `iMemRdata`  in  8  read data
- `oPairValid`  out  1  `oCurY`/`oRefY` valid, 1-cycle pulse
- `oCurY`  out  8  current-frame pixel
- `oRefY`  out  8  previous-frame pixel at the same index
- `oFrameDone`  out  1  1-cycle pulse at frame completion
- `oBusy`  out  1  high in every state except IDLE
- `oOverrun`  out  1  sticky; a pixel was dropped
- `oSyncErr`  out  1  sticky; `iFrameStart` arrived mid-frame

## Operation
- Registers:
  - state
  - `pix` (ADDR_W): current pixel index
  - `wrBank` (1): bank being written; the reference bank is ~`wrBank`
  - `refValid`: reference bank holds a complete frame
  - `stopReq`
  - latched pixel
- FSM transitions:
  - IDLE: `iStart` → ARM. Clears `oOverrun`, `oSyncErr` and `stopReq`.
  - ARM: `iFrameStart` → PIXW with `pix`=0. Strobes arriving in ARM are ignored and are not an overrun.
  - PIXW: `iEnLatch` → latch `iYdata`, go to RD.
  - RD: `oMemRe`=1, `oMemAddr`={~`wrBank`, `pix`} → WR.
  - WR:
    - Drives `oMemWe`=1, `oMemAddr`={`wrBank`, `pix`}, `oMemWdata`=latched pixel.
    - Captures `iMemRdata` as the reference pixel.
    - If `pix`==COLS*ROWS-1 → FEND.
    - Otherwise `pix`++. Then, if `iEnLatch` is high, latch it and go to RD; otherwise go to PIXW.
  - FEND:
    - `oFrameDone`=1, `wrBank` toggles, `refValid`←1, `pix`←0.
    - If `stopReq` → IDLE, otherwise → ARM.
- `oPairValid` pulses the cycle after WR, only when `refValid`=1. `oCurY` and `oRefY` hold their values until the next pair.
- Overrun:
  - `iEnLatch` in RD: the pixel is dropped and `oOverrun` is set.
  - `iEnLatch` in WR of the last pixel: the pixel is dropped and `oOverrun` is set.
  - A dropped pixel never advances `pix`.
- `iFrameStart` in PIXW, RD or WR:
  - Sets `oSyncErr`.
  - Abandons the partial frame: `pix`←0, bank is not toggled, no `oFrameDone`.
  - Next state is PIXW. Any RD/WR already in progress completes first, with its pair output suppressed.
- `iStop` in any non-IDLE state sets `stopReq`. `iStop` in ARM goes directly to IDLE.
- Memory strobes: at most one of `oMemRe`/`oMemWe` is high in any cycle. When neither is high, `oMemAddr` holds its last value.

## Timing
- Reset values:
  - All outputs 0.
  - state=IDLE, `pix`=0, `wrBank`=0, `refValid`=0, `stopReq`=0.
  - Reset mid-frame discards everything, including `refValid`.
- Pixel latency:
  - Strobe sampled at cycle T.
  - RD at T+1.
  - WR at T+2.
  - `oPairValid` at T+3.
- Throughput: one pixel per 2 cycles is sustained, since a strobe is accepted in WR. A strobe on consecutive cycles overruns.
- `oFrameDone`: asserted in the cycle after the last WR.
- ARM after FEND: entered at FEND+1. A frame start that occurs at FEND is missed, so sources must space frames by ≥2 cycles.

## Test plan
Parameters for all scenarios: COLS=4, ROWS=2, ADDR_W=3.
- Reset: assert `iReset` for 2 cycles mid-frame → all outputs 0, FSM in IDLE, `oBusy`=0; the next frame writes bank 0.
- First frame: `iStart`, then `iFrameStart`, then 8 strobes every 2 cycles with data 0x01..0x08 →
  - RD addresses 8..15, WR addresses 0..7 with data 0x01..0x08.
  - No `oPairValid`.
  - `oFrameDone` one cycle after the 8th WR.
- Second frame with data 0xFF →
  - RD addresses 0..7, WR addresses 8..15.
  - 8 `oPairValid` pulses with `oCurY`=0xFF and `oRefY`=0x01..0x08, each at strobe+3.
- Overrun: two strobes on consecutive cycles (0x10, 0x20) → only 0x10 is written, `oOverrun`=1, `pix` advances by 1. `oOverrun` stays high until IDLE followed by `iStart`.
- Sync error: `iFrameStart` after 3 pixels →
  - `oSyncErr`=1.
  - The next pixel writes index 0 in the same bank.
  - No `oFrameDone`.
- Stop: `iStop` pulsed mid-frame → the frame completes, `oFrameDone` pulses, FSM returns to IDLE, `oBusy`=0, and a following `iFrameStart` is ignored.

Source files
------------

// File: rtl/frame_array_ctrl_if.sv
// Bundle of the capture, memory and pair-output signals of frame_array_ctrl.
//   slave  : the controller view (capture/memory inputs in, strobes and pairs out)
//   master : the environment view (capture front end, pixel memory, consumer)
// Signals:
//   start, stop, frame_start, en_latch, y_data : capture control and pixel strobe
//   mem_addr, mem_re, mem_we, mem_wdata, mem_rdata : single-port pixel memory
//   pair_valid, cur_y, ref_y : {current, reference} pixel pair to the compare datapath
//   frame_done, busy, overrun, sync_err : status
interface frame_array_ctrl_if #(
  parameter int unsigned ADDR_W = 19
) ();
  logic              start;
  logic              stop;
  logic              frame_start;
  logic              en_latch;
  logic [7:0]        y_data;
  logic [ADDR_W:0]   mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              pair_valid;
  logic [7:0]        cur_y;
  logic [7:0]        ref_y;
  logic              frame_done;
  logic              busy;
  logic              overrun;
  logic              sync_err;

  modport slave (
    input  start, stop, frame_start, en_latch, y_data, mem_rdata,
    output mem_addr, mem_re, mem_we, mem_wdata, pair_valid, cur_y, ref_y,
    output frame_done, busy, overrun, sync_err
  );

  modport master (
    output start, stop, frame_start, en_latch, y_data, mem_rdata,
    input  mem_addr, mem_re, mem_we, mem_wdata, pair_valid, cur_y, ref_y,
    input  frame_done, busy, overrun, sync_err
  );
endinterface

// File: rtl/frame_array_ctrl.sv
// Frame store sequencer for the motion tracker. Each incoming luma pixel triggers a read of
// the co-located pixel of the previous frame from the reference bank, then a write of the new
// pixel into the write bank; banks swap at every completed frame.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : frame_array_ctrl_if.slave (capture strobes, pixel memory, pair output, status)
module frame_array_ctrl #(
  parameter int unsigned COLS   = 640,
  parameter int unsigned ROWS   = 480,
  parameter int unsigned ADDR_W = 19
) (
  input logic               clk,
  input logic               rst,
  frame_array_ctrl_if.slave bus
);

  localparam int unsigned NumPix = COLS * ROWS;
  localparam logic [ADDR_W-1:0] LastPix = ADDR_W'(NumPix - 1);

  typedef enum logic [2:0] {StIdle, StArm, StPixw, StRd, StWr, StFend} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic              wr_bank_q, wr_bank_d;
  logic              ref_valid_q, ref_valid_d;
  logic              stop_req_q, stop_req_d;
  logic [7:0]        lat_q, lat_d;
  // A frame start seen in RD must still let the following WR finish, but silently.
  logic              abort_q, abort_d;
  logic              overrun_q, overrun_d;
  logic              sync_err_q, sync_err_d;
  logic              pair_valid_q, pair_valid_d;
  logic [7:0]        cur_y_q, cur_y_d;
  logic [7:0]        ref_y_q, ref_y_d;
  logic [ADDR_W:0]   addr_q;
  logic              abort_now;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      pix_q        <= '0;
      wr_bank_q    <= 1'b0;
      ref_valid_q  <= 1'b0;
      stop_req_q   <= 1'b0;
      lat_q        <= '0;
      abort_q      <= 1'b0;
      overrun_q    <= 1'b0;
      sync_err_q   <= 1'b0;
      pair_valid_q <= 1'b0;
      cur_y_q      <= '0;
      ref_y_q      <= '0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      pix_q        <= pix_d;
      wr_bank_q    <= wr_bank_d;
      ref_valid_q  <= ref_valid_d;
      stop_req_q   <= stop_req_d;
      lat_q        <= lat_d;
      abort_q      <= abort_d;
      overrun_q    <= overrun_d;
      sync_err_q   <= sync_err_d;
      pair_valid_q <= pair_valid_d;
      cur_y_q      <= cur_y_d;
      ref_y_q      <= ref_y_d;
      // Address holds whenever no strobe is driven, since the output then mirrors addr_q.
      addr_q       <= bus.mem_addr;
    end
  end

  assign abort_now = abort_q | bus.frame_start;

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    pix_d        = pix_q;
    wr_bank_d    = wr_bank_q;
    ref_valid_d  = ref_valid_q;
    stop_req_d   = stop_req_q;
    lat_d        = lat_q;
    abort_d      = abort_q;
    overrun_d    = overrun_q;
    sync_err_d   = sync_err_q;
    pair_valid_d = 1'b0;
    cur_y_d      = cur_y_q;
    ref_y_d      = ref_y_q;

    if (state_q != StIdle && bus.stop) begin
      stop_req_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d    = StArm;
          overrun_d  = 1'b0;
          sync_err_d = 1'b0;
          stop_req_d = 1'b0;
        end
      end
      StArm: begin
        if (bus.stop) begin
          state_d = StIdle;
        end else if (bus.frame_start) begin
          state_d = StPixw;
          pix_d   = '0;
        end
      end
      StPixw: begin
        if (bus.frame_start) begin
          sync_err_d = 1'b1;
          pix_d      = '0;
        end else if (bus.en_latch) begin
          lat_d   = bus.y_data;
          state_d = StRd;
        end
      end
      StRd: begin
        if (bus.en_latch) begin
          overrun_d = 1'b1;
        end
        if (bus.frame_start) begin
          sync_err_d = 1'b1;
          abort_d    = 1'b1;
        end
        state_d = StWr;
      end
      StWr: begin
        abort_d      = 1'b0;
        pair_valid_d = ref_valid_q & ~abort_now;
        if (pair_valid_d) begin
          cur_y_d = lat_q;
          ref_y_d = bus.mem_rdata;
        end
        if (abort_now) begin
          if (bus.frame_start) begin
            sync_err_d = 1'b1;
          end
          pix_d   = '0;
          state_d = StPixw;
        end else if (pix_q == LastPix) begin
          if (bus.en_latch) begin
            overrun_d = 1'b1;
          end
          state_d = StFend;
        end else begin
          pix_d = pix_q + ADDR_W'(1);
          if (bus.en_latch) begin
            lat_d   = bus.y_data;
            state_d = StRd;
          end else begin
            state_d = StPixw;
          end
        end
      end
      StFend: begin
        wr_bank_d   = ~wr_bank_q;
        ref_valid_d = 1'b1;
        pix_d       = '0;
        state_d     = (stop_req_q || bus.stop) ? StIdle : StArm;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    bus.mem_re     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = addr_q;
    bus.mem_wdata  = lat_q;
    bus.frame_done = 1'b0;
    bus.busy       = (state_q != StIdle);
    bus.pair_valid = pair_valid_q;
    bus.cur_y      = cur_y_q;
    bus.ref_y      = ref_y_q;
    bus.overrun    = overrun_q;
    bus.sync_err   = sync_err_q;
    unique case (state_q)
      StRd: begin
        bus.mem_re   = 1'b1;
        bus.mem_addr = {~wr_bank_q, pix_q};
      end
      StWr: begin
        bus.mem_we   = 1'b1;
        bus.mem_addr = {wr_bank_q, pix_q};
      end
      StFend:  bus.frame_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_frame_array_ctrl.sv
module tb_frame_array_ctrl;

  typedef struct {
    int         cyc;
    logic [3:0] addr;
    logic [7:0] a;
    logic [7:0] b;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] mem [16];
  ev_t rd_log[$];
  ev_t wr_log[$];
  ev_t pair_log[$];
  int  done_log[$];

  frame_array_ctrl_if #(.ADDR_W(3)) bus ();

  frame_array_ctrl #(
    .COLS  (4),
    .ROWS  (2),
    .ADDR_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pixel memory with one cycle read latency
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (rst) bus.mem_rdata <= 8'h00;
    else if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_re) rd_log.push_back('{cyc, bus.mem_addr, 8'h00, 8'h00});
      if (bus.mem_we) wr_log.push_back('{cyc, bus.mem_addr, bus.mem_wdata, 8'h00});
      if (bus.pair_valid) pair_log.push_back('{cyc, 4'h0, bus.cur_y, bus.ref_y});
      if (bus.frame_done) done_log.push_back(cyc);
    end
  end

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic strobe(input logic [7:0] d, output int c);
    bus.en_latch = 1'b1;
    bus.y_data   = d;
    c = cyc;
    cycle();
    bus.en_latch = 1'b0;
  endtask

  task automatic pulse_frame_start();
    bus.frame_start = 1'b1;
    cycle();
    bus.frame_start = 1'b0;
  endtask

  task automatic test_reset();
    logic [34:0] outs;
    repeat (2) cycle();
    outs = {bus.mem_addr, bus.mem_re, bus.mem_we, bus.mem_wdata, bus.pair_valid, bus.cur_y,
            bus.ref_y, bus.frame_done, bus.busy, bus.overrun, bus.sync_err};
    checks++;
    if (outs !== 35'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    rst = 1'b0;
    repeat (2) cycle();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_first_frame();
    int sc[8];
    int rb = rd_log.size();
    int wb = wr_log.size();
    int pb = pair_log.size();
    int db = done_log.size();
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL first_arm_busy: got %b expected 1", bus.busy);
    end
    pulse_frame_start();
    for (int i = 0; i < 8; i++) begin
      strobe(8'(i + 1), sc[i]);
      cycle();
    end
    repeat (3) cycle();
    checks++;
    if (rd_log.size() - rb != 8 || wr_log.size() - wb != 8) begin
      errors++;
      $display("FAIL first_counts: got rd=%0d wr=%0d expected 8/8", rd_log.size() - rb,
               wr_log.size() - wb);
    end
    for (int i = 0; i < 8; i++) begin
      if (rd_log.size() > rb + i && wr_log.size() > wb + i) begin
        checks++;
        if (rd_log[rb+i].addr !== 4'(8 + i) || rd_log[rb+i].cyc != sc[i] + 1) begin
          errors++;
          $display("FAIL first_rd[%0d]: got addr=%0d cyc=%0d expected addr=%0d cyc=%0d", i,
                   rd_log[rb+i].addr, rd_log[rb+i].cyc, 8 + i, sc[i] + 1);
        end
        checks++;
        if (wr_log[wb+i].addr !== 4'(i) || wr_log[wb+i].a !== 8'(i + 1)
            || wr_log[wb+i].cyc != sc[i] + 2) begin
          errors++;
          $display("FAIL first_wr[%0d]: got addr=%0d data=%h cyc=%0d expected %0d/%h/%0d", i,
                   wr_log[wb+i].addr, wr_log[wb+i].a, wr_log[wb+i].cyc, i, i + 1, sc[i] + 2);
        end
      end
    end
    checks++;
    if (pair_log.size() != pb) begin
      errors++;
      $display("FAIL first_no_pairs: got %0d pairs expected 0", pair_log.size() - pb);
    end
    checks++;
    if (done_log.size() - db != 1 || done_log[db] != sc[7] + 3) begin
      errors++;
      $display("FAIL first_done: got count=%0d expected 1 at cycle %0d", done_log.size() - db,
               sc[7] + 3);
    end
  endtask

  task automatic test_second_frame();
    int sc[8];
    int rb = rd_log.size();
    int wb = wr_log.size();
    int pb = pair_log.size();
    int db = done_log.size();
    pulse_frame_start();
    for (int i = 0; i < 8; i++) begin
      strobe(8'hFF, sc[i]);
      cycle();
    end
    repeat (3) cycle();
    for (int i = 0; i < 8; i++) begin
      if (rd_log.size() > rb + i && wr_log.size() > wb + i) begin
        checks++;
        if (rd_log[rb+i].addr !== 4'(i) || wr_log[wb+i].addr !== 4'(8 + i)) begin
          errors++;
          $display("FAIL second_addr[%0d]: got rd=%0d wr=%0d expected rd=%0d wr=%0d", i,
                   rd_log[rb+i].addr, wr_log[wb+i].addr, i, 8 + i);
        end
      end
    end
    checks++;
    if (pair_log.size() - pb != 8) begin
      errors++;
      $display("FAIL second_pair_count: got %0d expected 8", pair_log.size() - pb);
    end
    for (int i = 0; i < 8; i++) begin
      if (pair_log.size() > pb + i) begin
        checks++;
        if (pair_log[pb+i].a !== 8'hFF || pair_log[pb+i].b !== 8'(i + 1)
            || pair_log[pb+i].cyc != sc[i] + 3) begin
          errors++;
          $display("FAIL second_pair[%0d]: got cur=%h ref=%h cyc=%0d expected FF/%h/%0d", i,
                   pair_log[pb+i].a, pair_log[pb+i].b, pair_log[pb+i].cyc, i + 1, sc[i] + 3);
        end
      end
    end
    checks++;
    if (done_log.size() - db != 1) begin
      errors++;
      $display("FAIL second_done: got %0d pulses expected 1", done_log.size() - db);
    end
  endtask

  task automatic test_overrun();
    int c;
    int wb = wr_log.size();
    int pb = pair_log.size();
    pulse_frame_start();
    strobe(8'h10, c);
    strobe(8'h20, c);   // consecutive cycle: lands in RD
    cycle();
    checks++;
    if (bus.overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: got %b expected 1", bus.overrun);
    end
    for (int i = 0; i < 7; i++) begin
      strobe(8'(8'h30 + i), c);
      cycle();
    end
    repeat (3) cycle();
    checks++;
    if (wr_log.size() - wb != 8) begin
      errors++;
      $display("FAIL overrun_wr_count: got %0d expected 8", wr_log.size() - wb);
    end else begin
      checks++;
      if (wr_log[wb].addr !== 4'd0 || wr_log[wb].a !== 8'h10 || wr_log[wb+1].addr !== 4'd1
          || wr_log[wb+1].a !== 8'h30) begin
        errors++;
        $display("FAIL overrun_writes: got %0d/%h %0d/%h expected 0/10 1/30", wr_log[wb].addr,
                 wr_log[wb].a, wr_log[wb+1].addr, wr_log[wb+1].a);
      end
    end
    checks++;
    if (pair_log.size() <= pb || pair_log[pb].a !== 8'h10 || pair_log[pb].b !== 8'hFF) begin
      errors++;
      $display("FAIL overrun_pair0: got %0d pairs expected first cur=10 ref=FF",
               pair_log.size() - pb);
    end
    checks++;
    if (bus.overrun !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: got overrun=%b busy=%b expected 1/1", bus.overrun,
               bus.busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    int c;
    int wb;
    int pb;
    int db;
    logic [34:0] outs;
    pulse_frame_start();
    strobe(8'h55, c);
    rst = 1'b1;
    wb = wr_log.size();
    repeat (2) cycle();
    outs = {bus.mem_addr, bus.mem_re, bus.mem_we, bus.mem_wdata, bus.pair_valid, bus.cur_y,
            bus.ref_y, bus.frame_done, bus.busy, bus.overrun, bus.sync_err};
    checks++;
    if (outs !== 35'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got %h expected 0", outs);
    end
    rst = 1'b0;
    cycle();
    checks++;
    if (wr_log.size() != wb || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle: got writes=%0d busy=%b expected 0/0", wr_log.size() - wb,
               bus.busy);
    end
    pb = pair_log.size();
    db = done_log.size();
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    pulse_frame_start();
    for (int i = 0; i < 8; i++) begin
      strobe(8'(8'h66 + i), c);
      cycle();
    end
    repeat (3) cycle();
    checks++;
    if (wr_log.size() - wb != 8 || wr_log[wb].addr !== 4'd0 || wr_log[wb].a !== 8'h66) begin
      errors++;
      $display("FAIL midreset_bank0: got count=%0d first addr=%0d data=%h expected 8/0/66",
               wr_log.size() - wb, wr_log[wb].addr, wr_log[wb].a);
    end
    checks++;
    if (pair_log.size() != pb || done_log.size() - db != 1) begin
      errors++;
      $display("FAIL midreset_refvalid: got pairs=%0d done=%0d expected 0/1",
               pair_log.size() - pb, done_log.size() - db);
    end
  endtask

  task automatic test_sync_err();
    int c;
    int wb = wr_log.size();
    int pb = pair_log.size();
    int db = done_log.size();
    pulse_frame_start();
    for (int i = 0; i < 3; i++) begin
      strobe(8'(8'h41 + i), c);
      cycle();
    end
    cycle();
    pulse_frame_start();
    checks++;
    if (bus.sync_err !== 1'b1) begin
      errors++;
      $display("FAIL sync_set: got %b expected 1", bus.sync_err);
    end
    strobe(8'h44, c);
    repeat (4) cycle();
    checks++;
    if (wr_log.size() - wb != 4) begin
      errors++;
      $display("FAIL sync_wr_count: got %0d expected 4", wr_log.size() - wb);
    end else begin
      checks++;
      if (wr_log[wb+2].addr !== 4'd10 || wr_log[wb+3].addr !== 4'd8
          || wr_log[wb+3].a !== 8'h44) begin
        errors++;
        $display("FAIL sync_restart: got %0d then %0d/%h expected 10 then 8/44",
                 wr_log[wb+2].addr, wr_log[wb+3].addr, wr_log[wb+3].a);
      end
    end
    checks++;
    if (pair_log.size() - pb != 4 || pair_log[pb+3].a !== 8'h44 || pair_log[pb+3].b !== 8'h66)
    begin
      errors++;
      $display("FAIL sync_pair: got count=%0d expected 4 with last cur=44 ref=66",
               pair_log.size() - pb);
    end
    checks++;
    if (done_log.size() != db) begin
      errors++;
      $display("FAIL sync_no_done: got %0d pulses expected 0", done_log.size() - db);
    end
  endtask

  task automatic test_stop();
    int c;
    int rb;
    int wb = wr_log.size();
    int db = done_log.size();
    bus.stop = 1'b1;
    cycle();
    bus.stop = 1'b0;
    for (int i = 0; i < 7; i++) begin
      strobe(8'(8'h71 + i), c);
      cycle();
    end
    repeat (3) cycle();
    checks++;
    if (wr_log.size() - wb != 7 || wr_log[wb].addr !== 4'd9 || wr_log[wb+6].addr !== 4'd15)
    begin
      errors++;
      $display("FAIL stop_writes: got count=%0d first=%0d expected 7 first=9",
               wr_log.size() - wb, wr_log[wb].addr);
    end
    checks++;
    if (done_log.size() - db != 1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_idle: got done=%0d busy=%b expected 1/0", done_log.size() - db,
               bus.busy);
    end
    rb = rd_log.size();
    wb = wr_log.size();
    pulse_frame_start();
    strobe(8'h99, c);
    repeat (4) cycle();
    checks++;
    if (rd_log.size() != rb || wr_log.size() != wb || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL stop_ignore_fs: got rd=%0d wr=%0d busy=%b expected 0/0/0",
               rd_log.size() - rb, wr_log.size() - wb, bus.busy);
    end
  endtask

  task automatic test_clear_flags();
    checks++;
    if (bus.sync_err !== 1'b1) begin
      errors++;
      $display("FAIL flags_sticky_idle: got %b expected 1", bus.sync_err);
    end
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
    checks++;
    if (bus.sync_err !== 1'b0 || bus.overrun !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL flags_cleared: got sync=%b ovr=%b busy=%b expected 0/0/1", bus.sync_err,
               bus.overrun, bus.busy);
    end
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.frame_start = 1'b0;
    bus.en_latch    = 1'b0;
    bus.y_data      = 8'h00;
    test_reset();
    test_first_frame();
    test_second_frame();
    test_overrun();
    test_reset_mid_frame();
    test_sync_err();
    test_stop();
    test_clear_flags();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
